bp_update_scheduler: RTL and testbench
======================================

# bp_update_scheduler

Serializes branch-resolution updates from the superscalar back end onto the single update port of the 2-bit branch predictor table. Up to NUM_PORTS resolved branches per cycle are packed in program order into a small circular queue. Entries are issued one per cycle as a registered update beat (pc, valid, misprediction). The block sits between the execute/commit lanes and the predictor's update interface in the fetch stage.

## Interface
- NUM_PORTS, 3, number of resolution lanes; lane 0 is oldest in program order
- ADDR_WIDTH, 32, PC width
- FIFO_DEPTH, 8, queue entries; power of two, ≥ NUM_PORTS
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled only on rising clk
- resolve_valid_i  in  NUM_PORTS  lane i carries a resolved branch/jump
- resolve_pc_i  in  NUM_PORTS×ADDR_WIDTH  PC of lane i
- resolve_mispredict_i  in  NUM_PORTS  lane i direction was mispredicted
- resolve_ready_o  out  1  queue can accept a full NUM_PORTS-lane group this cycle
- flush_i  in  1  discard all queued and in-flight updates
- update_prediction_pc_o  out  ADDR_WIDTH  PC to predictor
- update_prediction_valid_o  out  1  update beat valid
- misprediction_o  out  1  mispredict flag to predictor
- occupancy_o  out  CNT_WIDTH  current queue entry count

## Operation
- Queue: FIFO_DEPTH entries of {pc, mispredict}; write pointer wr_ptr, read pointer rd_ptr (log2 FIFO_DEPTH bits, wrap modulo FIFO_DEPTH); count held separately in CNT_WIDTH bits.
- Enqueue: a lane is accepted when resolve_valid_i[i] && resolve_ready_o. Accepted lanes are compacted in ascending lane order into slots wr_ptr, wr_ptr+1, … (mod FIFO_DEPTH). Invalid lanes leave no holes. n_enq = popcount of accepted lanes (0..NUM_PORTS). wr_ptr advances by n_enq.
- Ready: resolve_ready_o = (FIFO_DEPTH − count) ≥ NUM_PORTS. It is computed from registered count only; a same-cycle dequeue is not credited. It is all-or-nothing: if it is low, every lane is ignored and upstream must hold its lanes.
- Dequeue: when count > 0 and flush_i is low, the head entry loads into the output registers and rd_ptr advances by 1 (deq = 1). Otherwise update_prediction_valid_o loads 0, and the pc/mispredict outputs hold their previous value.
- Count: count_next = count + n_enq − deq. Simultaneous enqueue and dequeue are legal. count never exceeds FIFO_DEPTH.
- Flush (flush_i = 1, reset high): wr_ptr, rd_ptr and count clear to 0. update_prediction_valid_o loads 0. Enqueues in the flush cycle are dropped. Flush has priority over enqueue/dequeue.
- Reset (reset = 0 at an edge): overrides flush and all other activity. Pointers and count are 0. update_prediction_valid_o = 0, update_prediction_pc_o = 0, misprediction_o = 0, occupancy_o = 0, resolve_ready_o = 1. Queue storage contents are don't-care.
- occupancy_o = count (registered).
- No coalescing: repeated updates to the same predictor index are issued as separate beats in order.

## Timing
- Lanes accepted in cycle t are written at the edge ending t. The oldest of them is the queue head in t+1 if the queue was empty. It appears on the update outputs in cycle t+2 (latency 2).
- Throughput: one update beat per cycle while count > 0. A full-width group of NUM_PORTS drains in NUM_PORTS consecutive cycles.
- resolve_ready_o reflects count after the previous edge. Full (count = FIFO_DEPTH) → ready = 0. Empty → ready = 1.
- Flush asserted in cycle t: no update beat is valid in cycle t+1. Accepting resumes in t+1.
- Reset released in cycle t: inputs may be accepted in cycle t+1.

## Test plan
- Reset: hold reset = 0 for 2 cycles with lanes valid → all outputs 0, resolve_ready_o = 1, occupancy_o = 0; nothing is issued after release.
- Single lane: lane 1 valid, pc 0x0000_0104, mispredict 1 in cycle t → cycle t+2 outputs pc 0x104, valid 1, mispredict 1; cycle t+3 valid 0.
- Compaction/order: lanes 0 and 2 valid (pc 0x10, 0x18), lane 1 idle → beats 0x10 then 0x18 on consecutive cycles; occupancy_o goes 2→1→0.
- Backpressure/wrap: all 3 lanes valid every cycle → ready drops when count ≥ 6. Keep driving for 20 cycles → every accepted PC is issued exactly once, in order, across pointer wrap. No beat is lost when the queue reaches FIFO_DEPTH.
- Flush mid-drain: 5 entries queued, flush_i pulses one cycle with lane 0 valid → no valid beat the next cycle, occupancy_o = 0, flushed-cycle lane not issued.
- Reset mid-drain: reset = 0 with 4 entries queued and flush_i = 1 → same state as post-reset. A new update accepted after release issues normally.

Source files
------------

// File: rtl/bp_update_scheduler.sv
// Packs up to NUM_PORTS resolved branches per cycle into a circular queue and
// replays them one per cycle as registered update beats to the branch predictor.
module bp_update_scheduler #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 resolve_valid_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] resolve_pc_i,
  input  logic [NUM_PORTS-1:0]                 resolve_mispredict_i,
  output logic                                 resolve_ready_o,
  input  logic                                 flush_i,
  output logic [ADDR_WIDTH-1:0]                update_prediction_pc_o,
  output logic                                 update_prediction_valid_o,
  output logic                                 misprediction_o,
  output logic [CNT_WIDTH-1:0]                 occupancy_o
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ReadyLimit = CNT_WIDTH'(FIFO_DEPTH - NUM_PORTS);

  logic [PtrWidth-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]                count_q, count_d;
  logic [CNT_WIDTH-1:0]                n_enq;
  logic [NUM_PORTS-1:0]                accept;
  logic [NUM_PORTS-1:0][PtrWidth-1:0]  lane_slot;
  logic                                deq;

  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] mem_pc_q;
  logic [FIFO_DEPTH-1:0]                 mem_mis_q;

  logic [ADDR_WIDTH-1:0] upd_pc_q;
  logic                  upd_valid_q;
  logic                  upd_mis_q;

  // Ready looks only at the registered count; a same-cycle dequeue is not credited.
  assign resolve_ready_o = (count_q <= ReadyLimit);

  always_comb begin
    accept    = resolve_valid_i & {NUM_PORTS{resolve_ready_o & ~flush_i}};
    n_enq     = '0;
    lane_slot = '0;
    // Each accepted lane lands after all older accepted lanes, so idle lanes leave no holes.
    for (int i = 0; i < NUM_PORTS; i++) begin
      lane_slot[i] = wr_ptr_q + n_enq[PtrWidth-1:0];
      n_enq        = n_enq + CNT_WIDTH'(accept[i]);
    end
    deq = (count_q != '0) && !flush_i;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + n_enq[PtrWidth-1:0];
      rd_ptr_d = rd_ptr_q + PtrWidth'(deq);
      count_d  = count_q + n_enq - CNT_WIDTH'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_mis_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      upd_valid_q <= deq;
      if (deq) begin
        upd_pc_q  <= mem_pc_q[rd_ptr_q];
        upd_mis_q <= mem_mis_q[rd_ptr_q];
      end
    end
  end

  // Storage carries no reset; pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (accept[i]) begin
        mem_pc_q[lane_slot[i]]  <= resolve_pc_i[i];
        mem_mis_q[lane_slot[i]] <= resolve_mispredict_i[i];
      end
    end
  end

  assign update_prediction_pc_o    = upd_pc_q;
  assign update_prediction_valid_o = upd_valid_q;
  assign misprediction_o           = upd_mis_q;
  assign occupancy_o               = count_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed vector table plus a queue-based reference scoreboard for bp_update_scheduler.
module tb_bp_update_scheduler;

  localparam int unsigned NumPorts  = 3;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned FifoDepth = 8;
  localparam int unsigned CntWidth  = 4;

  logic                               clk;
  logic                               reset;
  logic [NumPorts-1:0]                rv;
  logic [NumPorts-1:0][AddrWidth-1:0] rpc;
  logic [NumPorts-1:0]                rmis;
  logic                               rdy;
  logic                               flush;
  logic [AddrWidth-1:0]               upc;
  logic                               uvalid;
  logic                               umis;
  logic [CntWidth-1:0]                occ;

  bp_update_scheduler #(
    .NUM_PORTS (NumPorts),
    .ADDR_WIDTH(AddrWidth),
    .FIFO_DEPTH(FifoDepth),
    .CNT_WIDTH (CntWidth)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .resolve_valid_i          (rv),
    .resolve_pc_i             (rpc),
    .resolve_mispredict_i     (rmis),
    .resolve_ready_o          (rdy),
    .flush_i                  (flush),
    .update_prediction_pc_o   (upc),
    .update_prediction_valid_o(uvalid),
    .misprediction_o          (umis),
    .occupancy_o              (occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: pending updates live in a queue, beats popped in order.
  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        sbq[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic        m_mis   = 1'b0;
  logic        m_acc   = 1'b0;
  logic        chk_en  = 1'b0;

  task automatic model_step();
    ent_t e;
    logic can_take;
    if (!reset) begin
      sbq.delete();
      m_valid = 1'b0;
      m_pc    = '0;
      m_mis   = 1'b0;
      m_acc   = 1'b0;
    end else if (flush) begin
      sbq.delete();
      m_valid = 1'b0;
      m_acc   = 1'b0;
    end else begin
      can_take = (FifoDepth - sbq.size()) >= NumPorts;
      if (sbq.size() > 0) begin
        e       = sbq.pop_front();
        m_valid = 1'b1;
        m_pc    = e.pc;
        m_mis   = e.mis;
      end else begin
        m_valid = 1'b0;
      end
      if (can_take) begin
        for (int i = 0; i < NumPorts; i++) begin
          if (rv[i]) begin
            e.pc  = rpc[i];
            e.mis = rmis[i];
            sbq.push_back(e);
          end
        end
      end
      m_acc = can_take;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_valid", 32'(uvalid), 32'(m_valid));
      chk("sb_pc", upc, m_pc);
      chk("sb_mis", 32'(umis), 32'(m_mis));
      chk("sb_occ", 32'(occ), 32'(sbq.size()));
      chk("sb_ready", 32'(rdy), 32'((FifoDepth - sbq.size()) >= NumPorts));
    end
  end

  // Each row: inputs for one cycle, outputs expected in the following cycle.
  typedef struct {
    logic        rst;
    logic        fl;
    logic [2:0]  v;
    logic [31:0] p0, p1, p2;
    logic [2:0]  m;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis;
    logic [3:0]  e_occ;
    logic        e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic rst_n, input logic fl, input logic [2:0] v,
                      input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                      input logic [2:0] m, input logic ev, input logic [31:0] epc,
                      input logic em, input logic [3:0] eocc, input logic erdy);
    vec_t r;
    r.rst = rst_n; r.fl = fl; r.v = v; r.p0 = p0; r.p1 = p1; r.p2 = p2; r.m = m;
    r.e_valid = ev; r.e_pc = epc; r.e_mis = em; r.e_occ = eocc; r.e_rdy = erdy;
    vq.push_back(r);
  endtask

  int          low_cnt;
  logic [31:0] base;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    rv    = '0;
    rpc   = '0;
    rmis  = '0;

    // reset held with lanes active, then release
    addv(0, 0, 3'b111, 32'hA0, 32'hA4, 32'hA8, 3'b111, 0, 32'h0,   0, 0, 1);
    addv(0, 1, 3'b111, 32'hA0, 32'hA4, 32'hA8, 3'b111, 0, 32'h0,   0, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h0,   0, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h0,   0, 0, 1);
    // single lane, latency 2
    addv(1, 0, 3'b010, 32'h0,  32'h104, 32'h0, 3'b010, 0, 32'h0,   0, 1, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 1, 32'h104, 1, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h104, 1, 0, 1);
    // compaction: lanes 0 and 2
    addv(1, 0, 3'b101, 32'h10, 32'hEE, 32'h18, 3'b100, 0, 32'h104, 1, 2, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 1, 32'h10,  0, 1, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 1, 32'h18,  1, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h18,  1, 0, 1);
    // flush mid-drain with 5 queued
    addv(1, 0, 3'b111, 32'h20, 32'h24, 32'h28, 3'b000, 0, 32'h18,  1, 3, 1);
    addv(1, 0, 3'b111, 32'h2C, 32'h30, 32'h34, 3'b000, 1, 32'h20,  0, 5, 1);
    addv(1, 1, 3'b001, 32'h40, 32'h0,  32'h0,  3'b001, 0, 32'h20,  0, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h20,  0, 0, 1);
    // reset mid-drain with flush asserted
    addv(1, 0, 3'b111, 32'h50, 32'h54, 32'h58, 3'b001, 0, 32'h20,  0, 3, 1);
    addv(1, 0, 3'b011, 32'h5C, 32'h60, 32'h0,  3'b000, 1, 32'h50,  1, 4, 1);
    addv(0, 1, 3'b111, 32'h70, 32'h74, 32'h78, 3'b111, 0, 32'h0,   0, 0, 1);
    addv(1, 0, 3'b100, 32'h0,  32'h0,  32'h80, 3'b100, 0, 32'h0,   0, 1, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 1, 32'h80,  1, 0, 1);
    addv(1, 0, 3'b000, 32'h0,  32'h0,  32'h0,  3'b000, 0, 32'h80,  1, 0, 1);

    @(negedge clk);
    foreach (vq[k]) begin
      reset  = vq[k].rst;
      flush  = vq[k].fl;
      rv     = vq[k].v;
      rpc[0] = vq[k].p0;
      rpc[1] = vq[k].p1;
      rpc[2] = vq[k].p2;
      rmis   = vq[k].m;
      @(negedge clk);
      chk_en = 1'b1;
      chk($sformatf("vec%0d_valid", k), 32'(uvalid), 32'(vq[k].e_valid));
      chk($sformatf("vec%0d_pc", k), upc, vq[k].e_pc);
      chk($sformatf("vec%0d_mis", k), 32'(umis), 32'(vq[k].e_mis));
      chk($sformatf("vec%0d_occ", k), 32'(occ), 32'(vq[k].e_occ));
      chk($sformatf("vec%0d_ready", k), 32'(rdy), 32'(vq[k].e_rdy));
    end

    // backpressure and wrap: all lanes valid, lanes held until accepted
    reset   = 1'b1;
    flush   = 1'b0;
    base    = 32'h1000;
    low_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!rdy) low_cnt++;
      rv = 3'b111;
      for (int i = 0; i < NumPorts; i++) begin
        rpc[i]  = base + 32'(4 * i);
        rmis[i] = base[2] ^ i[0];
      end
      @(negedge clk);
      if (m_acc) base = base + 32'd12;
    end
    rv = '0;
    repeat (12) @(negedge clk);
    chk("stress_ready_dropped", 32'(low_cnt > 0), 32'd1);
    chk("stress_all_issued", 32'(sbq.size()), 32'd0);
    chk("stress_final_occ", 32'(occ), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
